// File: rtl/pconv_ctrl_if.sv
// Handshake and memory-port bundle between the pointwise-conv controller and its environment.
// master: the controller side; slave: the datapath / host side.
interface pconv_ctrl_if #(
  parameter int PIX_W = 10,
  parameter int OC_W  = 3
);
  logic                   start;
  logic                   pause;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   fmap_rd_en;
  logic [PIX_W-1:0]       fmap_addr;
  logic                   w_rd_en;
  logic [OC_W-1:0]        w_addr;
  logic                   pu_input_vld;
  logic                   pu_dout_vld;
  logic                   out_we;
  logic [OC_W+PIX_W-1:0]  out_addr;
  logic [31:0]            perf_cycles;

  modport master (
    input  start, pause, pu_dout_vld,
    output busy, done, err, fmap_rd_en, fmap_addr, w_rd_en, w_addr,
           pu_input_vld, out_we, out_addr, perf_cycles
  );

  modport slave (
    output start, pause, pu_dout_vld,
    input  busy, done, err, fmap_rd_en, fmap_addr, w_rd_en, w_addr,
           pu_input_vld, out_we, out_addr, perf_cycles
  );
endinterface

// File: rtl/pconv_ctrl.sv
// Pointwise-conv sequencer: per output channel loads weights, streams pixels with an outstanding cap, writes results.
// Optional busy-cycle counter enabled by defining PCONV_CTRL_PERF_EN.
module pconv_ctrl #(
  parameter int N               = 16,
  parameter int OUTPUT_CHANNEL  = 8,
  parameter int PIXELS          = 784,
  parameter int PIX_W           = 10,
  parameter int OC_W            = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pconv_ctrl_if.master  bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
  localparam logic [OC_W-1:0]  OC_LAST  = OC_W'(OUTPUT_CHANNEL - 1);
  localparam logic [CNT_W:0]   MAX_OCC  = (CNT_W + 1)'(MAX_OUTSTANDING);

  if (N < 1 || PIXELS < 1 || PIXELS > (1 << PIX_W) || OUTPUT_CHANNEL < 1 ||
      OUTPUT_CHANNEL > (1 << OC_W) || MAX_OUTSTANDING < 1) begin : g_bad_params
    $error("pconv_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, LOAD_W, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [OC_W-1:0]   oc;
  logic [PIX_W-1:0]  issue_pix;
  logic [PIX_W-1:0]  ret_pix;
  logic [CNT_W-1:0]  outstanding;
  logic              input_vld_q;
  logic              err_q;

  logic              busy;
  logic              start_acc;
  logic              can_issue;
  logic              rd_fire;
  logic              wr_fire;
  logic              spurious;
  logic              pipe_empty;
  logic              ch_next;
  logic              w_rd_en;
  logic              done;
  logic [CNT_W:0]    occupancy;

  // Reads still travelling toward the datapath count against the cap just like unreturned results.
  assign occupancy  = {1'b0, outstanding} + {{CNT_W{1'b0}}, input_vld_q};
  assign busy       = (state != IDLE);
  assign start_acc  = (state == IDLE) && bus.start;
  assign can_issue  = (occupancy < MAX_OCC);
  assign rd_fire    = (state == ISSUE) && !bus.pause && can_issue;
  assign wr_fire    = bus.pu_dout_vld && busy && (outstanding != '0);
  assign spurious   = bus.pu_dout_vld && !wr_fire;
  assign pipe_empty = (outstanding == '0) && !input_vld_q;
  assign ch_next    = (state == DRAIN) && pipe_empty && (oc != OC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    w_rd_en   = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        w_rd_en   = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (rd_fire && (issue_pix == PIX_LAST)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty) state_nxt = (oc == OC_LAST) ? DONE : LOAD_W;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channel index only moves once the pipe is empty, so the weight address is stable for every in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc          <= '0;
      issue_pix   <= '0;
      ret_pix     <= '0;
      outstanding <= '0;
      input_vld_q <= 1'b0;
    end else begin
      input_vld_q <= rd_fire;
      if (start_acc) begin
        oc        <= '0;
        issue_pix <= '0;
        ret_pix   <= '0;
      end else if (ch_next) begin
        oc        <= oc + OC_W'(1);
        issue_pix <= '0;
        ret_pix   <= '0;
      end else begin
        if (rd_fire) issue_pix <= (issue_pix == PIX_LAST) ? '0 : issue_pix + PIX_W'(1);
        if (wr_fire) ret_pix   <= (ret_pix == PIX_LAST) ? '0 : ret_pix + PIX_W'(1);
      end
      case ({input_vld_q, wr_fire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (spurious) begin
      err_q <= 1'b1;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end
  end

`ifdef PCONV_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = 32'd0;
`endif

  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.err          = err_q;
  assign bus.fmap_rd_en   = rd_fire;
  assign bus.fmap_addr    = issue_pix;
  assign bus.w_rd_en      = w_rd_en;
  assign bus.w_addr       = oc;
  assign bus.pu_input_vld = input_vld_q;
  assign bus.out_we       = wr_fire;
  assign bus.out_addr     = {oc, ret_pix};

endmodule

// File: tb/tb_pconv_ctrl.sv
// Randomized bench for pconv_ctrl: a latency-queue datapath model plus a reference of the read/write order.
module tb_pconv_ctrl;

  localparam int N     = 16;
  localparam int OCH   = 2;
  localparam int PIX   = 4;
  localparam int PIX_W = 2;
  localparam int OC_W  = 1;
  localparam int MAXO  = 4;
  localparam int TOTAL = OCH * PIX;

  logic clk = 1'b0;
  logic rst_n;
  logic model_vld;
  logic spurious;

  pconv_ctrl_if #(.PIX_W(PIX_W), .OC_W(OC_W)) bus ();

  pconv_ctrl #(
    .N(N), .OUTPUT_CHANNEL(OCH), .PIXELS(PIX), .PIX_W(PIX_W),
    .OC_W(OC_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  assign bus.pu_dout_vld = model_vld | spurious;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 3;
  bit rand_pause = 1'b0;
  int unsigned due_q[$];

  int rd_total, wr_total, w_total, done_cnt, busy_cyc, wr_in_pause;
  int max_gap, last_rd_cyc, peak;
  bit prev_rd = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Datapath model: every accepted input emerges exactly lat cycles later.
  always @(posedge clk) begin
    cyc++;
    #1;
    model_vld = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      model_vld = 1'b1;
      void'(due_q.pop_front());
    end
  end

  // Reference: weights per channel in order, pixels 0..PIX-1 per channel, writes at linear addresses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy) busy_cyc++;
      if (bus.pu_input_vld || prev_rd) checkOutput("input_vld_align", bus.pu_input_vld, prev_rd);
      prev_rd = bus.fmap_rd_en;
      if (bus.pu_input_vld) due_q.push_back(cyc + lat);
      if (bus.w_rd_en) begin
        checkOutput("w_addr", bus.w_addr, w_total);
        checkOutput("w_pipe_empty", rd_total - wr_total, 0);
        w_total++;
      end
      if (bus.fmap_rd_en) begin
        checkOutput("rd_cap", (rd_total - wr_total) < MAXO, 1);
        checkOutput("rd_during_pause", bus.pause, 0);
        checkOutput("fmap_addr", bus.fmap_addr, rd_total % PIX);
        checkOutput("rd_channel", rd_total / PIX, w_total - 1);
        if ((rd_total % PIX) != 0 && (cyc - last_rd_cyc) > max_gap) max_gap = cyc - last_rd_cyc;
        last_rd_cyc = cyc;
        rd_total++;
        if ((rd_total - wr_total) > peak) peak = rd_total - wr_total;
      end
      if (bus.pu_dout_vld && !spurious) checkOutput("we_follows_vld", bus.out_we, 1);
      if (bus.out_we) begin
        checkOutput("out_addr", bus.out_addr, wr_total);
        wr_total++;
        if (bus.pause) wr_in_pause++;
      end
      if (bus.done) done_cnt++;
    end else begin
      prev_rd = 1'b0;
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_done"}, bus.done, 0);
    checkOutput({tag, "_err"}, bus.err, 0);
    checkOutput({tag, "_rd"}, bus.fmap_rd_en, 0);
    checkOutput({tag, "_wrd"}, bus.w_rd_en, 0);
    checkOutput({tag, "_ivld"}, bus.pu_input_vld, 0);
    checkOutput({tag, "_we"}, bus.out_we, 0);
    checkOutput({tag, "_perf"}, bus.perf_cycles, 0);
    checkOutput({tag, "_addrs"}, {bus.fmap_addr, bus.w_addr, bus.out_addr}, 0);
  endtask

  task automatic applyStimulus(input int l, input bit rp);
    rd_total = 0; wr_total = 0; w_total = 0; done_cnt = 0; busy_cyc = 0;
    wr_in_pause = 0; max_gap = 0; last_rd_cyc = 0; peak = 0;
    lat = l;
    rand_pause = rp;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("busy_after_start", bus.busy, 1);
    checkOutput("err_after_start", bus.err, 0);
  endtask

  task automatic waitDone(input int budget, input string tag);
    int n = 0;
    logic [31:0] exp_perf;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      if (rand_pause) bus.pause = ($urandom_range(3) == 0);
      n++;
    end
    bus.pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, "_done_once"}, done_cnt, 1);
    checkOutput({tag, "_writes"}, wr_total, TOTAL);
    checkOutput({tag, "_reads"}, rd_total, TOTAL);
    checkOutput({tag, "_busy_end"}, bus.busy, 0);
    checkOutput({tag, "_err_end"}, bus.err, 0);
`ifdef PCONV_CTRL_PERF_EN
    exp_perf = busy_cyc;
`else
    exp_perf = 0;
`endif
    checkOutput({tag, "_perf"}, bus.perf_cycles, exp_perf);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    spurious = 1'b0;
    model_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("por");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Unstalled run: pixels stream back to back
    applyStimulus(3, 1'b0);
    waitDone(300, "basic");
    checkOutput("basic_rd_gap", max_gap, 1);

    // Pause after pixel 1: two results drain while issue is frozen
    applyStimulus(3, 1'b0);
    n = 0;
    while (rd_total < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("pause_reached_pix1", rd_total, 2);
    bus.pause = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.pause = 1'b0;
    checkOutput("pause_reads_frozen", rd_total, 2);
    waitDone(300, "pause");
    checkOutput("pause_writes_during", wr_in_pause, 2);

    // Long latency saturates the outstanding cap
    applyStimulus(10, 1'b0);
    waitDone(400, "longlat");
    checkOutput("longlat_peak", peak, MAXO);

    // Stray result while idle
    @(posedge clk); #1;
    spurious = 1'b1;
    #1;
    checkOutput("spur_we", bus.out_we, 0);
    @(posedge clk); #1;
    spurious = 1'b0;
    checkOutput("spur_err", bus.err, 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("spur_err_sticky", bus.err, 1);
    applyStimulus(3, 1'b0);
    waitDone(300, "after_spur");

    // Reset after the third write abandons the run
    applyStimulus(3, 1'b0);
    n = 0;
    while (wr_total < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rst_reached_w3", wr_total, 3);
    #1;
    rst_n = 1'b0;
    due_q.delete();
    model_vld = 1'b0;
    #1;
    checkResetOutputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_no_done", done_cnt, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    applyStimulus(3, 1'b0);
    waitDone(300, "post_rst");

    // Random latency and random pauses
    for (int r = 0; r < 6; r++) begin
      applyStimulus($urandom_range(1, 10), 1'b1);
      waitDone(600, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
